// File: rtl/sender_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sender_pkg
// Description : Shared constants and types for the 40-bit serial sender and
//               its round-robin scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sender_pkg;

  // Width of one parallel word handed to the serial sender.
  localparam int WORD_W = 40;

  // Width of the shared ISSUE/GAP cycle counter.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sender_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or above ptr, wrapping modulo N_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  // (p + k) mod N_REQ without a divider; both operands are already < N_REQ.
  function automatic logic [IDX_W-1:0] wrap_add(input int p, input int k);
    int s;
    s = p + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Scan offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand = '0;
    any  = |req_valid;
    idx  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = wrap_add(int'(ptr), k);
      if (req_valid[cand]) idx = cand;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sender_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sender_scheduler
// Description : Round-robin scheduler sharing one serial sender among N_REQ
//               requesters: grants in IDLE, holds snd_valid for HOLD_CYCLES,
//               then cools down for GAP_CYCLES before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module sender_scheduler
  import sender_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WORD_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ack,
  output logic [WORD_W-1:0]          snd_data,
  output logic                       snd_valid,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(N_REQ);

  // Counter reload values: the counter reaches zero in the last cycle of a state.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);
  localparam bit               GAP_EN    = (GAP_CYCLES != 0);

  sched_state_t            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]        req_ack_q, req_ack_d;
  logic [WORD_W-1:0]       snd_data_q, snd_data_d;
  logic                    snd_valid_q, snd_valid_d;
  logic [IDX_W-1:0]        grant_id_q, grant_id_d;
  logic                    busy_q, busy_d;

  logic                    pick_any;
  logic [IDX_W-1:0]        pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  // Next-state, counter, pointer and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    req_ack_d  = '0;
    snd_data_d = snd_data_q;
    grant_id_d = grant_id_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d              = ISSUE;
          cnt_d                = HOLD_LOAD;
          ptr_d                = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          snd_data_d           = req_data[pick_idx*WORD_W +: WORD_W];
          grant_id_d           = pick_idx;
          req_ack_d[pick_idx]  = 1'b1;
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          if (GAP_EN) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Valid and busy are registered images of the state being entered.
    snd_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      req_ack_q   <= '0;
      snd_data_q  <= '0;
      snd_valid_q <= 1'b0;
      grant_id_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      req_ack_q   <= req_ack_d;
      snd_data_q  <= snd_data_d;
      snd_valid_q <= snd_valid_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign snd_data  = snd_data_q;
  assign snd_valid = snd_valid_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sender_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sender_scheduler
// Description : Self-checking bench for sender_scheduler (N_REQ=4, HOLD=2,
//               GAP=4): directed table, corner sequences, random traffic
//               against a timing-rule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sender_scheduler;

  localparam int N      = 4;
  localparam int H      = 2;
  localparam int G      = 4;
  localparam int PERIOD = H + G + 1;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*40-1:0] req_data;
  logic [N-1:0]    req_ack;
  logic [39:0]     snd_data;
  logic            snd_valid;
  logic [1:0]      grant_id;
  logic            busy;

  sender_scheduler #(
    .N_REQ       (N),
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .snd_data  (snd_data),
    .snd_valid (snd_valid),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Stimulus state
  logic [N-1:0] req_vec;
  logic [39:0]  words [N];
  int           ack_edge;

  // Reference model: last grant edge plus pointer, outputs derived from elapsed time
  int           edge_n = 0;
  int           m_last = -1000;
  int           m_ptr  = 0;
  int           m_gid  = 0;
  logic [39:0]  m_data = '0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_edge();
    int  win;
    bit  found;
    edge_n++;
    if (rst) begin
      m_ptr  = 0;
      m_last = -1000;
      m_gid  = 0;
      m_data = '0;
    end else if (edge_n >= m_last + PERIOD && req_valid != '0) begin
      found = 0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          win   = (m_ptr + k) % N;
          found = 1;
        end
      end
      m_last = edge_n;
      m_gid  = win;
      m_data = req_data[win*40 +: 40];
      m_ptr  = (win + 1) % N;
    end
  endtask

  task automatic model_check();
    int           d;
    logic [N-1:0] e_ack;
    d     = edge_n - m_last;
    e_ack = (d == 0) ? N'(1 << m_gid) : '0;
    cmp("m_ack",       64'(req_ack),   64'(e_ack));
    cmp("m_snd_valid", 64'(snd_valid), 64'(d < H));
    cmp("m_busy",      64'(busy),      64'(d < H + G));
    cmp("m_snd_data",  64'(snd_data),  64'(m_data));
    cmp("m_grant_id",  64'(grant_id),  64'(m_gid));
    cmp("m_ptr",       64'(dut.ptr_q), 64'(m_ptr));
  endtask

  task automatic step(input logic r);
    @(negedge clk);
    rst       = r;
    req_valid = req_vec;
    for (int i = 0; i < N; i++) req_data[i*40 +: 40] = words[i];
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic wait_ack(input int budget, input bit drop, output int idx);
    idx = -1;
    for (int c = 0; c < budget && idx < 0; c++) begin
      step(1'b0);
      if (req_ack != '0) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) idx = i;
        ack_edge = edge_n;
        if (drop) req_vec[idx] = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic        sv;
    logic        busy;
    logic [1:0]  gid;
    logic [39:0] data;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] a, logic sv,
                              logic b, logic [1:0] g, logic [39:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a; v.sv = sv; v.busy = b; v.gid = g; v.data = d;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [39:0] w0, w2;
    logic [3:0]  pending;
    int          idx, e0, n_ack;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_vec   = '0;
    words[0]  = 40'h11_2233_4455;
    words[1]  = 40'h66_7788_99AA;
    words[2]  = 40'hD9_9999_9991;
    words[3]  = 40'hBB_CCDD_EEFF;
    w0 = words[0];
    w2 = words[2];

    // Reset with all requesting, first grant, then requester 2 alone, then
    // requester 0 pulsing only during the cooldown.
    tbl[0]  = mk(1, 4'b1111, 4'b0000, 0, 0, 0, '0);
    tbl[1]  = mk(1, 4'b1111, 4'b0000, 0, 0, 0, '0);
    tbl[2]  = mk(1, 4'b1111, 4'b0000, 0, 0, 0, '0);
    tbl[3]  = mk(0, 4'b1111, 4'b0001, 1, 1, 0, w0);
    tbl[4]  = mk(0, 4'b0000, 4'b0000, 1, 1, 0, w0);
    tbl[5]  = mk(0, 4'b0000, 4'b0000, 0, 1, 0, w0);
    tbl[6]  = mk(0, 4'b0000, 4'b0000, 0, 1, 0, w0);
    tbl[7]  = mk(0, 4'b0000, 4'b0000, 0, 1, 0, w0);
    tbl[8]  = mk(0, 4'b0000, 4'b0000, 0, 1, 0, w0);
    tbl[9]  = mk(0, 4'b0000, 4'b0000, 0, 0, 0, w0);
    tbl[10] = mk(0, 4'b0100, 4'b0100, 1, 1, 2, w2);
    tbl[11] = mk(0, 4'b0000, 4'b0000, 1, 1, 2, w2);
    tbl[12] = mk(0, 4'b0000, 4'b0000, 0, 1, 2, w2);
    tbl[13] = mk(0, 4'b0001, 4'b0000, 0, 1, 2, w2);
    tbl[14] = mk(0, 4'b0001, 4'b0000, 0, 1, 2, w2);
    tbl[15] = mk(0, 4'b0001, 4'b0000, 0, 1, 2, w2);
    tbl[16] = mk(0, 4'b0001, 4'b0000, 0, 0, 2, w2);
    tbl[17] = mk(0, 4'b0000, 4'b0000, 0, 0, 2, w2);

    for (int r = 0; r < 18; r++) begin
      req_vec = tbl[r].req;
      step(tbl[r].rst);
      cmp($sformatf("tbl%0d_ack", r),  64'(req_ack),   64'(tbl[r].ack));
      cmp($sformatf("tbl%0d_sv", r),   64'(snd_valid), 64'(tbl[r].sv));
      cmp($sformatf("tbl%0d_busy", r), 64'(busy),      64'(tbl[r].busy));
      cmp($sformatf("tbl%0d_gid", r),  64'(grant_id),  64'(tbl[r].gid));
      cmp($sformatf("tbl%0d_data", r), 64'(snd_data),  64'(tbl[r].data));
    end

    // Round robin with all four held continuously: 0,1,2,3,0 seven cycles apart.
    req_vec = '0;
    step(1'b1);
    step(1'b1);
    req_vec = 4'b1111;
    e0 = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(3 * PERIOD, 1'b0, idx);
      cmp($sformatf("rr_order%0d", k), 64'(idx), 64'(k % N));
      cmp($sformatf("rr_gid%0d", k), 64'(grant_id), 64'(k % N));
      if (k > 0) cmp($sformatf("rr_spacing%0d", k), 64'(ack_edge - e0), 64'(PERIOD));
      e0 = ack_edge;
    end

    // Pointer wrap and skip: grant 3, then only 1 and 2 request.
    req_vec = '0;
    step(1'b1);
    req_vec = 4'b1000;
    wait_ack(3 * PERIOD, 1'b1, idx);
    cmp("wrap_first", 64'(idx), 64'(3));
    req_vec = req_vec | 4'b0110;
    wait_ack(3 * PERIOD, 1'b1, idx);
    cmp("wrap_second", 64'(idx), 64'(1));
    wait_ack(3 * PERIOD, 1'b1, idx);
    cmp("wrap_third", 64'(idx), 64'(2));

    // Request raised during ISSUE waits for IDLE.
    req_vec = '0;
    step(1'b1);
    req_vec = 4'b0001;
    wait_ack(3 * PERIOD, 1'b1, idx);
    cmp("issue_first", 64'(idx), 64'(0));
    e0 = ack_edge;
    req_vec = 4'b0010;
    wait_ack(3 * PERIOD, 1'b1, idx);
    cmp("issue_wait_idx", 64'(idx), 64'(1));
    cmp("issue_wait_gap", 64'(ack_edge - e0), 64'(PERIOD));

    // Reset during the second ISSUE cycle.
    req_vec = '0;
    step(1'b1);
    req_vec = 4'b0100;
    wait_ack(3 * PERIOD, 1'b1, idx);
    cmp("mid_grant", 64'(idx), 64'(2));
    step(1'b0);
    cmp("mid_sv_before", 64'(snd_valid), 64'(1));
    step(1'b1);
    cmp("mid_sv_after",   64'(snd_valid),  64'(0));
    cmp("mid_busy_after", 64'(busy),       64'(0));
    cmp("mid_ptr_after",  64'(dut.ptr_q),  64'(0));
    n_ack = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0);
      if (req_ack != '0) n_ack++;
    end
    cmp("mid_no_dup_ack", 64'(n_ack), 64'(0));

    // Random traffic obeying the requester contract, with occasional resets.
    pending = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) pending[i] = 1'b0;
        if (!pending[i] && $urandom_range(3) == 0) begin
          pending[i] = 1'b1;
          words[i]   = {8'($urandom), $urandom};
        end else if (pending[i] && $urandom_range(31) == 0) begin
          pending[i] = 1'b0;
        end
      end
      req_vec = pending;
      step($urandom_range(63) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
